adc_ng_detect: RTL and testbench

Noise-gate detector for one ADC monitor channel. It sits directly upstream of the channel power-sequencing FSM and drives that FSM's `ng_active` and `ng_pdn_ana` inputs. It watches the decimated ADC sample stream and asserts `ng_active` after a programmable run of consecutive quiet samples. After a further delay it can request analog power-down; an analog signal-detect comparator wakes the channel back up.

---
 rtl/adc_ng_detect.sv | 165 ++++++++++++++++
 tb/tb_adc_ng_detect.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ng_detect.sv
// Noise-gate detector for one ADC monitor channel. It closes the gate after a
// run of quiet samples, can then request analog power-down, and reopens on a
// loud sample or on the analog signal-detect comparator.
module adc_ng_detect #(
  parameter int SW = 16,
  parameter int HW = 12,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rsb,
  input  logic                 sample_valid,
  input  logic signed [SW-1:0] sample,
  input  logic                 powered_up,
  input  logic                 sig_det_ana,
  input  logic                 cp_ng_en,
  input  logic [SW-2:0]        cp_ng_thresh_lo,
  input  logic [SW-2:0]        cp_ng_thresh_hi,
  input  logic [HW-1:0]        cp_ng_hold_cnt,
  input  logic                 cp_ng_pdn_en,
  input  logic [DW-1:0]        cp_ng_pdn_dly,
  output logic                 ng_active,
  output logic                 ng_pdn_ana,
  output logic [1:0]           ng_state
);

  // state | meaning
  // OFF   | gate disabled, counters held at 0
  // OPEN  | enabled, waiting for the first quiet sample
  // HOLD  | counting consecutive quiet samples in q_cnt
  // GATED | gate closed, p_cnt runs toward the power-down delay
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_OPEN  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GATED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] q_cnt_q, q_cnt_d;
  logic [DW-1:0] p_cnt_q, p_cnt_d;
  logic          ng_active_q, ng_active_d;
  logic          ng_pdn_q, ng_pdn_d;
  logic          sd_meta_q, sd_meta_d;
  logic          sig_det_s_q, sig_det_s_d;

  logic [SW-1:0] neg_s;
  logic [SW-2:0] mag;
  logic          is_min;
  logic          quiet;
  logic          loud;
  logic [HW-1:0] hold_eff;
  logic [HW-1:0] q_inc;
  logic [DW-1:0] p_nxt;

  // Most-negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    neg_s  = -sample;
    is_min = (sample == {1'b1, {(SW-1){1'b0}}});
    if (!sample[SW-1]) begin
      mag = sample[SW-2:0];
    end else if (is_min) begin
      mag = '1;
    end else begin
      mag = neg_s[SW-2:0];
    end
  end

  always_comb begin
    quiet    = (mag < cp_ng_thresh_lo);
    loud     = (mag >= cp_ng_thresh_hi);
    hold_eff = (cp_ng_hold_cnt == '0) ? HW'(1) : cp_ng_hold_cnt;
    q_inc    = (&q_cnt_q) ? q_cnt_q : q_cnt_q + HW'(1);
    // Clamp rather than hold so a lowered delay still reaches equality.
    p_nxt    = (p_cnt_q >= cp_ng_pdn_dly) ? cp_ng_pdn_dly : p_cnt_q + DW'(1);
  end

  always_comb begin
    sd_meta_d   = sig_det_ana;
    sig_det_s_d = sd_meta_q;
  end

  always_comb begin
    state_d = state_q;
    q_cnt_d = q_cnt_q;
    p_cnt_d = p_cnt_q;
    if (!cp_ng_en) begin
      state_d = ST_OFF;
      q_cnt_d = '0;
      p_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_OPEN;
          q_cnt_d = '0;
          p_cnt_d = '0;
        end
        ST_OPEN: begin
          if (sample_valid && quiet && powered_up) begin
            q_cnt_d = HW'(1);
            state_d = (hold_eff == HW'(1)) ? ST_GATED : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!powered_up) begin
            state_d = ST_OPEN;
            q_cnt_d = '0;
          end else if (sample_valid) begin
            if (quiet) begin
              q_cnt_d = q_inc;
              if (q_inc >= hold_eff) state_d = ST_GATED;
            end else begin
              state_d = ST_OPEN;
              q_cnt_d = '0;
            end
          end
        end
        ST_GATED: begin
          // Loud wins over quiet here even when the thresholds overlap.
          if ((sample_valid && loud) || sig_det_s_q) begin
            state_d = ST_OPEN;
            q_cnt_d = '0;
            p_cnt_d = '0;
          end else begin
            p_cnt_d = p_nxt;
          end
        end
        default: begin
          state_d = ST_OFF;
          q_cnt_d = '0;
          p_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ng_active_d = (state_d == ST_GATED);
    ng_pdn_d    = (state_d == ST_GATED) && cp_ng_pdn_en && (p_cnt_d == cp_ng_pdn_dly);
  end

  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      state_q     <= ST_OFF;
      q_cnt_q     <= '0;
      p_cnt_q     <= '0;
      ng_active_q <= 1'b0;
      ng_pdn_q    <= 1'b0;
      sd_meta_q   <= 1'b0;
      sig_det_s_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_cnt_q     <= q_cnt_d;
      p_cnt_q     <= p_cnt_d;
      ng_active_q <= ng_active_d;
      ng_pdn_q    <= ng_pdn_d;
      sd_meta_q   <= sd_meta_d;
      sig_det_s_q <= sig_det_s_d;
    end
  end

  assign ng_active  = ng_active_q;
  assign ng_pdn_ana = ng_pdn_q;
  assign ng_state   = state_q;

endmodule

// File: tb/tb_adc_ng_detect.sv
// Scoreboard bench for adc_ng_detect: expected outputs are queued with the
// stimulus, observed outputs are queued on the checking edge, and each scenario
// drains and compares both queues.
module tb_adc_ng_detect;

  localparam int SW = 16;
  localparam int HW = 12;
  localparam int DW = 8;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GATED = 2'd3;

  logic                 clk = 1'b0;
  logic                 rsb;
  logic                 sample_valid;
  logic signed [SW-1:0] sample;
  logic                 powered_up;
  logic                 sig_det_ana;
  logic                 cp_ng_en;
  logic [SW-2:0]        cp_ng_thresh_lo;
  logic [SW-2:0]        cp_ng_thresh_hi;
  logic [HW-1:0]        cp_ng_hold_cnt;
  logic                 cp_ng_pdn_en;
  logic [DW-1:0]        cp_ng_pdn_dly;
  logic                 ng_active;
  logic                 ng_pdn_ana;
  logic [1:0]           ng_state;

  typedef struct packed {
    logic       act;
    logic       pdn;
    logic [1:0] st;
  } out_t;

  out_t  exp_q[$];
  out_t  obs_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  adc_ng_detect #(.SW(SW), .HW(HW), .DW(DW)) dut (
    .clk             (clk),
    .rsb             (rsb),
    .sample_valid    (sample_valid),
    .sample          (sample),
    .powered_up      (powered_up),
    .sig_det_ana     (sig_det_ana),
    .cp_ng_en        (cp_ng_en),
    .cp_ng_thresh_lo (cp_ng_thresh_lo),
    .cp_ng_thresh_hi (cp_ng_thresh_hi),
    .cp_ng_hold_cnt  (cp_ng_hold_cnt),
    .cp_ng_pdn_en    (cp_ng_pdn_en),
    .cp_ng_pdn_dly   (cp_ng_pdn_dly),
    .ng_active       (ng_active),
    .ng_pdn_ana      (ng_pdn_ana),
    .ng_state        (ng_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string n, input logic a, input logic p, input logic [1:0] s);
    out_t e;
    e.act = a; e.pdn = p; e.st = s;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic rec();
    out_t o;
    o.act = ng_active; o.pdn = ng_pdn_ana; o.st = ng_state;
    obs_q.push_back(o);
  endtask

  task automatic send(input logic signed [SW-1:0] v);
    sample_valid = 1'b1;
    sample       = v;
    tick();
    sample_valid = 1'b0;
    sample       = '0;
  endtask

  task automatic cfg(input int lo, input int hi, input int hold, input logic pe, input int dly);
    cp_ng_thresh_lo = (SW-1)'(lo);
    cp_ng_thresh_hi = (SW-1)'(hi);
    cp_ng_hold_cnt  = HW'(hold);
    cp_ng_pdn_en    = pe;
    cp_ng_pdn_dly   = DW'(dly);
  endtask

  task automatic test_reset();
    out_t e, o;
    string n;
    rsb = 1'b0; sample_valid = 1'b0; sample = '0; powered_up = 1'b0;
    sig_det_ana = 1'b0; cp_ng_en = 1'b0;
    cfg(100, 200, 4, 1'b1, 10);
    tick(); tick();
    expect_out("reset_state", 1'b0, 1'b0, S_OFF); rec();
    rsb = 1'b1;
    tick();
    expect_out("disabled_stays_off", 1'b0, 1'b0, S_OFF); rec();
    cp_ng_en = 1'b1; powered_up = 1'b1;
    tick();
    expect_out("enable_to_open", 1'b0, 1'b0, S_OPEN); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_basic();
    out_t e, o;
    string n;
    cfg(100, 200, 4, 1'b1, 10);
    expect_out("basic_s1", 1'b0, 1'b0, S_HOLD);  send(16'sd50);  rec();
    send(-16'sd60);
    expect_out("basic_s3", 1'b0, 1'b0, S_HOLD);  send(16'sd99);  rec();
    expect_out("basic_gate", 1'b1, 1'b0, S_GATED); send(-16'sd99); rec();
    for (int i = 0; i < 9; i++) tick();
    expect_out("basic_pdn_before", 1'b1, 1'b0, S_GATED); rec();
    tick();
    expect_out("basic_pdn_at_dly", 1'b1, 1'b1, S_GATED); rec();
    expect_out("basic_release", 1'b0, 1'b0, S_OPEN); send(16'sd250); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_hold_interrupted();
    out_t e, o;
    string n;
    send(16'sd10); send(-16'sd10);
    expect_out("intr_hold3", 1'b0, 1'b0, S_HOLD); send(16'sd20); rec();
    expect_out("intr_break", 1'b0, 1'b0, S_OPEN); send(16'sd150); rec();
    send(16'sd1); send(-16'sd2);
    expect_out("intr_hold3_again", 1'b0, 1'b0, S_HOLD); send(16'sd3); rec();
    expect_out("intr_gate", 1'b1, 1'b0, S_GATED); send(-16'sd4); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_wake();
    out_t e, o;
    string n;
    for (int i = 0; i < 10; i++) tick();
    expect_out("wake_pdn_up", 1'b1, 1'b1, S_GATED); rec();
    sig_det_ana = 1'b1;
    tick();
    sig_det_ana = 1'b0;
    expect_out("wake_edge1", 1'b1, 1'b1, S_GATED); rec();
    tick();
    expect_out("wake_edge2", 1'b1, 1'b1, S_GATED); rec();
    tick();
    expect_out("wake_edge3", 1'b0, 1'b0, S_OPEN); rec();
    tick();
    expect_out("wake_settled", 1'b0, 1'b0, S_OPEN); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_edges();
    out_t e, o;
    string n;
    cfg(100, 200, 0, 1'b1, 0);
    expect_out("edge_mag_eq_lo", 1'b0, 1'b0, S_OPEN); send(16'sd100); rec();
    expect_out("edge_hold0_dly0", 1'b1, 1'b1, S_GATED); send(16'sd5); rec();
    cp_ng_thresh_hi = 15'h7fff;
    expect_out("edge_min_is_loud", 1'b0, 1'b0, S_OPEN); send(-16'sd32768); rec();
    cfg(300, 200, 0, 1'b1, 0);
    expect_out("edge_overlap_quiet", 1'b1, 1'b1, S_GATED); send(16'sd250); rec();
    expect_out("edge_overlap_loud", 1'b0, 1'b0, S_OPEN); send(-16'sd250); rec();
    cfg(100, 200, 4, 1'b1, 10);
    send(16'sd10); send(16'sd20);
    expect_out("edge_hold_q3", 1'b0, 1'b0, S_HOLD); send(16'sd30); rec();
    cp_ng_hold_cnt = HW'(2);
    expect_out("edge_hold_lowered", 1'b1, 1'b0, S_GATED); send(16'sd40); rec();
    expect_out("edge_exit", 1'b0, 1'b0, S_OPEN); send(16'sd200); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_disable();
    out_t e, o;
    string n;
    cfg(100, 200, 4, 1'b1, 10);
    send(16'sd1); send(16'sd2); send(16'sd3);
    expect_out("dis_gate", 1'b1, 1'b0, S_GATED); send(16'sd4); rec();
    powered_up = 1'b0;
    tick(); tick(); tick();
    expect_out("dis_pu0_in_gated", 1'b1, 1'b0, S_GATED); rec();
    powered_up = 1'b1; cp_ng_en = 1'b0;
    tick();
    expect_out("dis_en0_off", 1'b0, 1'b0, S_OFF); rec();
    cp_ng_en = 1'b1;
    tick();
    expect_out("dis_reenable", 1'b0, 1'b0, S_OPEN); rec();
    send(16'sd1);
    expect_out("dis_hold", 1'b0, 1'b0, S_HOLD); send(16'sd2); rec();
    powered_up = 1'b0;
    tick();
    expect_out("dis_pu0_in_hold", 1'b0, 1'b0, S_OPEN); rec();
    powered_up = 1'b1;
    send(16'sd1);
    expect_out("dis_hold_again", 1'b0, 1'b0, S_HOLD); send(16'sd2); rec();
    #2 rsb = 1'b0;
    #1;
    expect_out("dis_async_reset", 1'b0, 1'b0, S_OFF); rec();
    tick();
    rsb = 1'b1;
    tick();
    expect_out("dis_after_reset", 1'b0, 1'b0, S_OPEN); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  task automatic test_pdn_disabled();
    out_t e, o;
    string n;
    cfg(100, 200, 4, 1'b0, 10);
    send(-16'sd7); send(16'sd8); send(-16'sd9);
    expect_out("pdn_dis_gate", 1'b1, 1'b0, S_GATED); send(16'sd0); rec();
    for (int i = 0; i < 300; i++) begin
      tick();
      expect_out("pdn_dis_hold", 1'b1, 1'b0, S_GATED); rec();
    end
    expect_out("pdn_dis_release", 1'b0, 1'b0, S_OPEN); send(16'sd300); rec();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = name_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s: no observation, expected act=%0b pdn=%0b st=%0d", n, e.act, e.pdn, e.st);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got act=%0b pdn=%0b st=%0d, expected act=%0b pdn=%0b st=%0d", n, o.act, o.pdn, o.st, e.act, e.pdn, e.st);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_interrupted();
    test_wake();
    test_edges();
    test_disable();
    test_pdn_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
